// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, default timing constants and a
// counter-width helper, common to uart_rx and uart_tx.
package uart_rx_pkg;

  localparam int DEFAULT_DVSR       = 27;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BIT   = 8;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_STOP      = 3'd3;
  localparam uart_state_t ST_WAIT_HIGH = 3'd4;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial input, received data, status pulses and
// a debug view of the FSM state.
interface uart_rx_if #(
  parameter int DATA_BIT = uart_rx_pkg::DEFAULT_DATA_BIT
) ();

  logic                      i_rx;
  logic [DATA_BIT-1:0]       o_data;
  logic                      o_rx_done_tick;
  logic                      o_frame_err;
  logic                      o_busy;
  uart_rx_pkg::uart_state_t  dbg_state;

  // No ready path: o_rx_done_tick and o_frame_err are single-cycle valid
  // pulses that the consumer must capture in the cycle they are high; o_data
  // is stable from a done pulse until the next one.
  modport master (
    output i_rx,
    input  o_data,
    input  o_rx_done_tick,
    input  o_frame_err,
    input  o_busy,
    input  dbg_state
  );

  modport slave (
    input  i_rx,
    output o_data,
    output o_rx_done_tick,
    output o_frame_err,
    output o_busy,
    output dbg_state
  );

endinterface

// File: rtl/uart_rx_baud_gen.sv
// Free-running mod-DVSR divider that emits a one-cycle sample tick; it is
// never stopped or re-phased, so the transmitter can share it.
module baud_gen
  import uart_rx_pkg::*;
#(
  parameter int DVSR = DEFAULT_DVSR
) (
  input  logic clk,
  input  logic rst,
  output logic s_tick
);

  localparam int            CW        = cnt_width(DVSR);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign s_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizes the line, finds the start-bit
// centre, samples each data bit mid-period and validates the stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BIT   = DEFAULT_DATA_BIT,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DVSR       = DEFAULT_DVSR
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  localparam int            TW        = cnt_width(OVERSAMPLE);
  localparam int            BW        = cnt_width(DATA_BIT);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BIT - 1);

  logic s_tick;

  baud_gen #(
    .DVSR (DVSR)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .s_tick (s_tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_state_t          state_q,    state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_BIT-1:0]  shreg_q,    shreg_d;
  logic [DATA_BIT-1:0]  data_q,     data_d;
  logic                 done_q,     done_d;
  logic                 ferr_q,     ferr_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            // A line that is high again at the start-bit centre was a glitch.
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s_q, shreg_q[DATA_BIT-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = ST_STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            // Returning to IDLE at mid stop bit leaves half a bit to catch a
            // back-to-back start edge.
            if (rx_s_q) begin
              data_d  = shreg_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.o_data         = data_q;
  assign bus.o_rx_done_tick = done_q;
  assign bus.o_frame_err    = ferr_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, received bytes checked
// against an expected queue filled as each good frame is sent.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DATA_BIT   = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DVSR       = 27;
  localparam int BCLK       = DVSR * OVERSAMPLE;
  localparam int LAT_TICKS  = (DATA_BIT + 1) * OVERSAMPLE + OVERSAMPLE / 2;

  logic clk;
  logic rst;

  uart_rx_if #(.DATA_BIT(DATA_BIT)) bus ();

  uart_rx #(
    .DATA_BIT   (DATA_BIT),
    .OVERSAMPLE (OVERSAMPLE),
    .DVSR       (DVSR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [DATA_BIT-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DATA_BIT-1:0] exp_v;
    if (!rst && (bus.o_rx_done_tick || bus.o_frame_err)) begin
      checks++;
      if (bus.o_rx_done_tick && bus.o_frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: done=1 frame_err=1, required not both");
      end
      if (bus.o_frame_err) ferr_cnt++;
      if (bus.o_rx_done_tick) begin
        done_cnt++;
        last_done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: data=%02h with empty expected queue", bus.o_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.o_data !== exp_v) begin
            errors++;
            $display("FAIL rx_data: got %02h required %02h", bus.o_data, exp_v);
          end
        end
      end
    end
  end

  // Drivers
  task automatic send_byte(input logic [DATA_BIT-1:0] d, input logic stop_bit,
                           input int bclk);
    bus.i_rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < DATA_BIT; i++) begin
      bus.i_rx = d[i];
      repeat (bclk) @(negedge clk);
    end
    bus.i_rx = stop_bit;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    bus.i_rx = 1'b1;
    repeat (n * BCLK) @(negedge clk);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((bus.o_busy || exp_q.size() != 0) && n < 3 * BCLK) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3 * BCLK) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle and empty",
               name, bus.o_busy, exp_q.size());
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    bus.i_rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.o_data !== '0 || bus.o_rx_done_tick !== 1'b0 || bus.o_frame_err !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: data=%02h done=%0b ferr=%0b busy=%0b state=%0d, required all 0",
               bus.o_data, bus.o_rx_done_tick, bus.o_frame_err, bus.o_busy, bus.dbg_state);
    end
    rst = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_single();
    int d0, f0, edge_cyc, lat;
    d0 = done_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    edge_cyc = cyc;
    send_byte(8'h55, 1'b1, BCLK);
    wait_quiet("single");
    checks++;
    if (done_cnt - d0 != 1 || ferr_cnt != f0 || bus.o_data !== 8'h55) begin
      errors++;
      $display("FAIL single_55: dones=%0d ferrs=%0d data=%02h, required 1 0 55",
               done_cnt - d0, ferr_cnt - f0, bus.o_data);
    end
    lat = last_done_cyc - edge_cyc;
    checks++;
    if (lat < (LAT_TICKS - 1) * DVSR || lat > (LAT_TICKS + 1) * DVSR + 4) begin
      errors++;
      $display("FAIL latency: got %0d clk, required %0d..%0d", lat,
               (LAT_TICKS - 1) * DVSR, (LAT_TICKS + 1) * DVSR + 4);
    end
    idle_bits(1);
  endtask

  task automatic test_back_to_back();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    for (int b = 1; b <= 9; b++) begin
      exp_q.push_back(DATA_BIT'(b));
      send_byte(DATA_BIT'(b), 1'b1, BCLK);
    end
    wait_quiet("b2b");
    checks++;
    if (done_cnt - d0 != 9 || ferr_cnt != f0 || bus.o_data !== 8'h09) begin
      errors++;
      $display("FAIL back_to_back: dones=%0d ferrs=%0d data=%02h, required 9 0 09",
               done_cnt - d0, ferr_cnt - f0, bus.o_data);
    end
    idle_bits(1);
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    bus.i_rx = 1'b0;
    repeat (4 * DVSR) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (BCLK) @(negedge clk);
    checks++;
    if (done_cnt != d0 || ferr_cnt != f0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch: dones=%0d ferrs=%0d busy=%0b, required 0 0 0",
               done_cnt - d0, ferr_cnt - f0, bus.o_busy);
    end
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA3, 1'b0, BCLK);
    repeat (3 * BCLK) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.dbg_state !== ST_WAIT_HIGH) begin
      errors++;
      $display("FAIL break_hold: busy=%0b state=%0d, required 1 %0d",
               bus.o_busy, bus.dbg_state, ST_WAIT_HIGH);
    end
    idle_bits(1);
    checks++;
    if (ferr_cnt - f0 != 1 || done_cnt != d0 || bus.o_data !== 8'h09 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err: ferrs=%0d dones=%0d data=%02h busy=%0b, required 1 0 09 0",
               ferr_cnt - f0, done_cnt - d0, bus.o_data, bus.o_busy);
    end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BCLK);
    wait_quiet("after_ferr");
    checks++;
    if (bus.o_data !== 8'h3C || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL after_ferr: data=%02h dones=%0d, required 3c 1", bus.o_data, done_cnt - d0);
    end
    idle_bits(1);
  endtask

  task automatic test_reset_midframe();
    int d0, f0;
    bus.i_rx = 1'b0;
    repeat (BCLK) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (4 * BCLK + BCLK / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_data !== '0 || bus.o_rx_done_tick !== 1'b0 || bus.o_frame_err !== 1'b0 ||
        bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: data=%02h done=%0b ferr=%0b busy=%0b, required all 0",
               bus.o_data, bus.o_rx_done_tick, bus.o_frame_err, bus.o_busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt; f0 = ferr_cnt;
    idle_bits(2);
    checks++;
    if (done_cnt != d0 || ferr_cnt != f0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: dones=%0d ferrs=%0d busy=%0b, required 0 0 0",
               done_cnt - d0, ferr_cnt - f0, bus.o_busy);
    end
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, BCLK);
    wait_quiet("after_reset");
    checks++;
    if (bus.o_data !== 8'h12 || done_cnt - d0 != 1 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL after_reset: data=%02h dones=%0d ferrs=%0d, required 12 1 0",
               bus.o_data, done_cnt - d0, ferr_cnt - f0);
    end
    idle_bits(1);
  endtask

  task automatic test_baud_mismatch();
    int d0, f0;
    int bclks[2];
    bclks[0] = (BCLK * 103) / 100;
    bclks[1] = (BCLK * 97) / 100;
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt; f0 = ferr_cnt;
      exp_q.push_back(8'h80);
      send_byte(8'h80, 1'b1, bclks[k]);
      wait_quiet("mismatch");
      checks++;
      if (bus.o_data !== 8'h80 || done_cnt - d0 != 1 || ferr_cnt != f0) begin
        errors++;
        $display("FAIL baud_mismatch_%0d: data=%02h dones=%0d ferrs=%0d, required 80 1 0",
                 bclks[k], bus.o_data, done_cnt - d0, ferr_cnt - f0);
      end
      idle_bits(1);
    end
  endtask

  // Sequence and final report
  initial begin
    rst = 1'b1;
    bus.i_rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_baud_mismatch();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d entries pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BIT, default 8: data bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLE, default 16: sample ticks per bit period.
REQ-003 Parameter DVSR, default 27: clk cycles per sample tick (50 MHz / (16 x 115200)).
REQ-004 One clock, clk; reset is asynchronous and active-high, named rst.
REQ-005 Port clk, input, 1: system clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port i_rx, input, 1: asynchronous serial line; idle is high.
REQ-008 Port o_data, output, DATA_BIT: last correctly framed byte; feeds the downstream packet decoder's i_data.
REQ-009 Port o_rx_done_tick, output, 1: one-cycle pulse when o_data has been updated; feeds the decoder's i_rx_done_tick.
REQ-010 Port o_frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
REQ-011 Port o_busy, output, 1: high in every state except IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized line rx_s only.
REQ-013 The sample tick SHALL come from a free-running mod-DVSR counter that pulses s_tick for one cycle every DVSR clk cycles; it is never stopped or re-phased.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: when rx_s = 0, go to START and clear the tick counter.
REQ-016 START: at s_tick count OVERSAMPLE/2-1, if rx_s = 1, treat it as a glitch and return to IDLE with no output; else clear counters and go to DATA.
REQ-017 DATA: every OVERSAMPLE s_ticks, shift rx_s into the MSB of the shift register (shift right); after DATA_BIT samples, go to STOP.
REQ-018 STOP: after OVERSAMPLE s_ticks (mid stop bit), check rx_s.
REQ-019 If the stop bit is 1: load o_data from the shift register, pulse o_rx_done_tick in that same cycle, and go to IDLE.
REQ-020 If the stop bit is 0: pulse o_frame_err, leave o_data unchanged, give no done tick, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rx_s = 1, then go to IDLE; a break condition of any length SHALL yield exactly one o_frame_err pulse.
REQ-022 o_rx_done_tick and o_frame_err SHALL never be high in the same cycle.
REQ-023 Back-to-back frames with zero idle bits SHALL be received; IDLE is re-entered at mid stop, so the next start edge is caught.
REQ-024 Latency: o_rx_done_tick SHALL occur (DATA_BIT+1)xOVERSAMPLE + OVERSAMPLE/2 s_ticks after the first s_tick following start-edge detection, +/- 1 s_tick for phase, plus 2 clk for the synchronizer.
REQ-025 o_data SHALL hold its value between done ticks.
REQ-026 The tick counter width SHALL be ceil(log2(OVERSAMPLE)) and the bit counter width ceil(log2(DATA_BIT)); both wrap to 0 on reload, never by overflow.

Reset
REQ-027 With rst high: state = IDLE, o_data = 0, o_rx_done_tick = 0, o_frame_err = 0, o_busy = 0, all counters = 0, shift register = 0, and synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes at the next falling edge after release.

Structure
REQ-029 State encodings and the default DVSR/OVERSAMPLE values SHALL live in a shared package used by uart_rx and the future uart_tx.
REQ-030 The mod-DVSR tick generator SHALL be a separate sub-module, baud_gen, with one s_tick output, reusable by uart_tx.

Verification
REQ-031 DVSR=27, send 0x55 at 115200 baud -> one o_rx_done_tick, o_data = 0x55, o_frame_err never high.
REQ-032 Send 9 bytes 0x01..0x09 back-to-back with no idle bits -> exactly 9 done ticks, o_data sequence 0x01..0x09.
REQ-033 Drive i_rx low for 4 sample ticks, then high -> no done tick, no frame_err, o_busy returns low.
REQ-034 Frame 0xA3 with stop bit forced 0, then line low for 3 bit times -> one o_frame_err, o_data keeps its prior value, then 0x3C is received correctly.
REQ-035 Assert rst during data bit 4 of 0xFF -> all outputs 0 immediately; the next frame, 0x12, is received correctly.
REQ-036 Frame 0x80 with +/-3% baud mismatch -> o_data = 0x80, no frame error.
